segvect_match_resolver: RTL and testbench
=========================================

Name:
segvect_match_resolver

Overview:
- Downstream stage of the mask-vector stage in the TCAM search path.
- Consumes the masked 130-bit segment vector (13 segments × {2-bit status, 8-bit rule ID}).
- Decides whether the vector identifies a single rule, looks up that rule's priority, and keeps the best match across a multi-vector search frame.
- Emits one {match, rule ID, priority} result word (CFWID) per frame to the result collector.

Parameters:
- KWID, 104, key width.
- SEGWID, 10, segment width (2 status + 8 ID).
- MASKWID, KWID/8 = 13, segment count.
- VTWID, SEGWID*MASKWID = 130, vector width.
- IDWID, 8, rule ID width.
- PRIOR, 8, priority width.
- CFWID, 1+IDWID+PRIOR = 17, result width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_Vect_Valid  in  1  i_Mask_Vect valid this cycle.
- i_Vect_Last  in  1  qualifies the last vector of a search frame; ignored unless i_Vect_Valid.
- i_Mask_Vect  in  VTWID  segment k: status at [10k+9:10k+8], ID at [10k+7:10k].
- i_Prio_We  in  1  priority table write enable.
- i_Prio_Addr  in  IDWID  priority table write address (rule ID).
- i_Prio_Data  in  PRIOR  priority to write.
- o_Result_Valid  out  1  one-cycle pulse per frame.
- o_Result  out  CFWID  {match[16], rule ID[15:8], priority[7:0]}.

Behaviour:
- Segment status decode:
  - 2'b11: masked / don't-care, ignored.
  - 2'b01: valid; its ID participates.
  - 2'b00 or 2'b10: empty, kills the vector.
- Stage 1 (registered decode):
  - cand_id = ID of the lowest-index valid segment.
  - hit = no killed segment AND at least one valid segment AND every valid segment ID == cand_id.
  - All-masked vector → hit=0.
- Stage 2 (table lookup):
  - Priority table: 2^IDWID × PRIOR, synchronous read of cand_id. Not reset; contents undefined until written.
  - Write happens on the clock edge when i_Prio_We=1.
  - A read of the same address in the same cycle returns the old value (read-first).
- Stage 3 (accumulator FSM):
  - IDLE: on a valid vector, load best = {hit, id, prio}, or {0,0,0} if no hit. Go to ACCUM, or straight to EMIT if last.
  - ACCUM: on each valid vector with hit, replace best if (!best.match) OR prio > best.prio OR (prio == best.prio AND id < best.id). On last, go to EMIT.
  - EMIT: o_Result_Valid=1 for one cycle with best (including the last vector). Best clears.
  - If a new vector arrives while in EMIT, it loads as the first vector of the next frame (back-to-back frames, zero bubble).
- Result encoding and timing:
  - No-match result is exactly 17'h0.
  - Latency: vector with last at cycle t → o_Result_Valid at t+3.
  - Throughput: one vector per cycle.
- Framing:
  - Gaps (i_Vect_Valid=0) inside a frame are allowed.
  - A 1-vector frame (valid & last together) is legal.
- Reset (async, rst=0):
  - All pipeline valids, FSM (→ IDLE), best, o_Result_Valid and o_Result cleared to 0.
  - Reset mid-frame discards the partial frame; no result is emitted.
  - Table contents are unaffected.
- No backpressure: the consumer must accept every o_Result_Valid pulse.

Optional Feature:
- SEGVECT_HITCNT_EN defined:
  - Adds output o_Hit_Cnt [15:0].
  - Increments by 1 on each emitted result with match=1; saturates at 16'hFFFF.
  - Cleared by reset.
- SEGVECT_HITCNT_EN undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package holds:
  - width constants KWID, SEGWID, MASKWID, VTWID, IDWID, PRIOR, CFWID;
  - status encodings ST_VALID=2'b01, ST_MASKED=2'b11;
  - result struct typedef {match, id, prio};
  - FSM state enum {IDLE, ACCUM, EMIT}.
- One sub-module: prio_table_ram (1W/1R synchronous, read-first), so it maps to block RAM.

Test Plan:
1. Write prio[0x2A]=0x50; single frame, all 13 segments {01,0x2A} → o_Result=17'h12A50 at t+3.
2. Same vector but segment 4 status 2'b00 → o_Result=17'h0, o_Result_Valid still pulses.
3. Segments 0–11 status 11, segment 12 {01,0x07}, prio[0x07]=0x33 → 17'h10733. All 13 segments status 11 → 17'h0.
4. 3-vector frame with IDs 0x10/0x11/0x12, prio 0x20/0x90/0x90 → 17'h11190 (tie resolves to lower ID). Immediate back-to-back 1-vector frame ID 0x10 → 17'h11020 on the next cycle.
5. Segment 0 {01,0x01}, segment 1 {01,0x02}, rest 11 → 17'h0. Write prio[0x05]=0x0A the same cycle the stage-2 read of 0x05 occurs → old value used; next frame sees 0x0A.
6. Assert rst after 2 vectors of a frame, then release → no o_Result_Valid. Next 1-vector frame returns the correct result. With SEGVECT_HITCNT_EN, o_Hit_Cnt counts only match frames and holds at 16'hFFFF.

Source files
------------

// File: rtl/segvect_match_resolver_pkg.sv
// Shared widths, segment status encodings, result word layout and FSM states
// for the segment-vector match resolver.
package segvect_match_resolver_pkg;

    localparam int KWID    = 104;
    localparam int SEGWID  = 10;
    localparam int MASKWID = KWID / 8;
    localparam int VTWID   = SEGWID * MASKWID;
    localparam int IDWID   = 8;
    localparam int PRIOR   = 8;
    localparam int CFWID   = 1 + IDWID + PRIOR;

    // Segment status field: only these two codes keep a vector alive.
    localparam logic [1:0] ST_VALID  = 2'b01;
    localparam logic [1:0] ST_MASKED = 2'b11;

    typedef struct packed {
        logic             match;
        logic [IDWID-1:0] id;
        logic [PRIOR-1:0] prio;
    } result_t;

    localparam result_t RES_NONE = '{match: 1'b0, id: 8'h00, prio: 8'h00};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    // Returns the better of the running best and a new candidate. A candidate
    // without a hit never wins; on equal priority the lower rule ID wins.
    function automatic result_t pick_best(input result_t base, input result_t cand);
        result_t r;
        r = base;
        if (cand.match) begin
            if (!base.match || (cand.prio > base.prio) ||
                ((cand.prio == base.prio) && (cand.id < base.id))) begin
                r = cand;
            end else begin
                r = base;
            end
        end else begin
            r = base;
        end
        return r;
    endfunction

endpackage

// File: rtl/segvect_match_resolver_prio_table_ram.sv
// Rule priority table: one write port, one synchronous read port, read-first.
// No reset so the array can map onto block RAM.
module prio_table_ram
    import segvect_match_resolver_pkg::*;
#(
    parameter int AW = IDWID,
    parameter int DW = PRIOR
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [0:(2**AW)-1];

    // Write and registered read on the same edge; the read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/segvect_match_resolver.sv
// Segment-vector match resolver: decodes each masked segment vector into a
// single-rule hit, looks up the rule priority and keeps the best match over a
// search frame, emitting one {match, id, prio} word per frame, three cycles
// after the frame's last vector.
// Optional build macro: SEGVECT_HITCNT_EN adds o_Hit_Cnt, a saturating count
// of emitted results with match=1.
module segvect_match_resolver
    import segvect_match_resolver_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_Vect_Valid,
    input  logic             i_Vect_Last,
    input  logic [VTWID-1:0] i_Mask_Vect,
    input  logic             i_Prio_We,
    input  logic [IDWID-1:0] i_Prio_Addr,
    input  logic [PRIOR-1:0] i_Prio_Data,
`ifdef SEGVECT_HITCNT_EN
    output logic [15:0]      o_Hit_Cnt,
`endif
    output logic             o_Result_Valid,
    output logic [CFWID-1:0] o_Result
);

    // Stage 1 decode results
    logic             kill_s;
    logic             found_s;
    logic             diff_s;
    logic             hit_s;
    logic [IDWID-1:0] cand_id_s;

    logic             s1_valid_r, s1_last_r, s1_hit_r;
    logic [IDWID-1:0] s1_id_r;
    logic             s2_valid_r, s2_last_r, s2_hit_r;
    logic [IDWID-1:0] s2_id_r;
    logic [PRIOR-1:0] s2_prio_s;

    state_t  state_r, state_s;
    result_t best_r, best_s;
    result_t res_r, res_s;
    logic    res_valid_r, res_valid_s;
    result_t base_s, cand_s, merged_s;

    // Scan all segments: first valid ID is the candidate, any empty segment
    // or any differing valid ID disqualifies the vector.
    always_comb begin
        kill_s    = 1'b0;
        found_s   = 1'b0;
        diff_s    = 1'b0;
        cand_id_s = 8'h00;
        for (int k = 0; k < MASKWID; k++) begin
            case (i_Mask_Vect[k*SEGWID+IDWID +: 2])
                ST_VALID: begin
                    if (!found_s) begin
                        cand_id_s = i_Mask_Vect[k*SEGWID +: IDWID];
                        found_s   = 1'b1;
                    end else if (i_Mask_Vect[k*SEGWID +: IDWID] != cand_id_s) begin
                        diff_s = 1'b1;
                    end else begin
                        diff_s = diff_s;
                    end
                end
                ST_MASKED: kill_s = kill_s;
                default:   kill_s = 1'b1;
            endcase
        end
        hit_s = found_s & ~kill_s & ~diff_s;
    end

    // Pipeline registers for stage 1 (decode) and stage 2 (table lookup).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_hit_r   <= 1'b0;
            s1_id_r    <= 8'h00;
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
            s2_hit_r   <= 1'b0;
            s2_id_r    <= 8'h00;
        end else begin
            s1_valid_r <= i_Vect_Valid;
            s1_last_r  <= i_Vect_Valid & i_Vect_Last;
            s1_hit_r   <= hit_s;
            s1_id_r    <= cand_id_s;
            s2_valid_r <= s1_valid_r;
            s2_last_r  <= s1_last_r;
            s2_hit_r   <= s1_hit_r;
            s2_id_r    <= s1_id_r;
        end
    end

    prio_table_ram #(
        .AW (IDWID),
        .DW (PRIOR)
    ) u_prio_table (
        .clk   (clk),
        .we    (i_Prio_We),
        .waddr (i_Prio_Addr),
        .wdata (i_Prio_Data),
        .raddr (s1_id_r),
        .rdata (s2_prio_s)
    );

    // Accumulator next-state: a frame starts fresh in IDLE or EMIT, merges
    // into the running best in ACCUM, and the last vector emits the result.
    always_comb begin
        state_s     = state_r;
        best_s      = best_r;
        res_s       = res_r;
        res_valid_s = 1'b0;
        cand_s      = '{match: s2_hit_r, id: s2_id_r, prio: s2_prio_s};
        case (state_r)
            ACCUM:   base_s = best_r;
            default: base_s = RES_NONE;
        endcase
        merged_s = pick_best(base_s, cand_s);
        case (state_r)
            IDLE, EMIT: begin
                if (s2_valid_r) begin
                    if (s2_last_r) begin
                        res_s       = merged_s;
                        res_valid_s = 1'b1;
                        best_s      = RES_NONE;
                        state_s     = EMIT;
                    end else begin
                        best_s  = merged_s;
                        state_s = ACCUM;
                    end
                end else begin
                    best_s  = RES_NONE;
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (s2_valid_r) begin
                    if (s2_last_r) begin
                        res_s       = merged_s;
                        res_valid_s = 1'b1;
                        best_s      = RES_NONE;
                        state_s     = EMIT;
                    end else begin
                        best_s  = merged_s;
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = ACCUM;
                end
            end
            default: begin
                best_s  = RES_NONE;
                state_s = IDLE;
            end
        endcase
    end

    // Accumulator state, running best and registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            best_r      <= RES_NONE;
            res_r       <= RES_NONE;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            best_r      <= best_s;
            res_r       <= res_s;
            res_valid_r <= res_valid_s;
        end
    end

    assign o_Result_Valid = res_valid_r;
    assign o_Result       = res_r;

`ifdef SEGVECT_HITCNT_EN
    logic [15:0] hit_cnt_r;

    // Saturating count of emitted results that carry a match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_r <= 16'h0000;
        end else if (res_valid_s && res_s.match && (hit_cnt_r != 16'hFFFF)) begin
            hit_cnt_r <= hit_cnt_r + 16'h0001;
        end
    end

    assign o_Hit_Cnt = hit_cnt_r;
`endif

endmodule

// File: tb/tb_segvect_match_resolver.sv
// Directed self-checking bench for segvect_match_resolver.
module tb_segvect_match_resolver;
    import segvect_match_resolver_pkg::*;

    logic             clk;
    logic             rst;
    logic             i_Vect_Valid;
    logic             i_Vect_Last;
    logic [VTWID-1:0] i_Mask_Vect;
    logic             i_Prio_We;
    logic [IDWID-1:0] i_Prio_Addr;
    logic [PRIOR-1:0] i_Prio_Data;
    logic             o_Result_Valid;
    logic [CFWID-1:0] o_Result;
`ifdef SEGVECT_HITCNT_EN
    logic [15:0]      o_Hit_Cnt;
`endif

    int errors = 0;
    int checks = 0;
    int exp_hits = 0;

    segvect_match_resolver dut (
        .clk            (clk),
        .rst            (rst),
        .i_Vect_Valid   (i_Vect_Valid),
        .i_Vect_Last    (i_Vect_Last),
        .i_Mask_Vect    (i_Mask_Vect),
        .i_Prio_We      (i_Prio_We),
        .i_Prio_Addr    (i_Prio_Addr),
        .i_Prio_Data    (i_Prio_Data),
`ifdef SEGVECT_HITCNT_EN
        .o_Hit_Cnt      (o_Hit_Cnt),
`endif
        .o_Result_Valid (o_Result_Valid),
        .o_Result       (o_Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VTWID-1:0] uniform(input logic [1:0] st, input logic [7:0] id);
        logic [VTWID-1:0] v;
        for (int k = 0; k < MASKWID; k++) v[k*SEGWID +: SEGWID] = {st, id};
        return v;
    endfunction

    function automatic logic [VTWID-1:0] set_seg(input logic [VTWID-1:0] v, input int k,
                                                 input logic [1:0] st, input logic [7:0] id);
        logic [VTWID-1:0] r;
        r = v;
        r[k*SEGWID +: SEGWID] = {st, id};
        return r;
    endfunction

    task automatic drive_vec(input logic [VTWID-1:0] v, input logic last);
        i_Vect_Valid = 1'b1;
        i_Vect_Last  = last;
        i_Mask_Vect  = v;
        step();
        i_Vect_Valid = 1'b0;
        i_Vect_Last  = 1'b0;
    endtask

    task automatic write_prio(input logic [7:0] addr, input logic [7:0] data);
        i_Prio_We   = 1'b1;
        i_Prio_Addr = addr;
        i_Prio_Data = data;
        step();
        i_Prio_We = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_Vect_Valid = 1'b0;
        i_Vect_Last  = 1'b0;
        i_Mask_Vect  = '0;
        i_Prio_We    = 1'b0;
        i_Prio_Addr  = 8'h00;
        i_Prio_Data  = 8'h00;
        step();
        step();
        checks++;
        if (o_Result_Valid !== 1'b0 || o_Result !== 17'h00000) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b result=%h, want valid=0 result=00000", o_Result_Valid, o_Result);
        end
`ifdef SEGVECT_HITCNT_EN
        checks++;
        if (o_Hit_Cnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hitcnt: got %h want 0000", o_Hit_Cnt);
        end
`endif
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_rule();
        write_prio(8'h2A, 8'h50);
        drive_vec(uniform(2'b01, 8'h2A), 1'b1);
        step();
        checks++;
        if (o_Result_Valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_early: valid=%b at t+2, want 0", o_Result_Valid);
        end
        step();
        checks++;
        if (o_Result_Valid !== 1'b1 || o_Result !== 17'h12A50) begin
            errors++;
            $display("FAIL t1_result: valid=%b result=%h, want valid=1 result=12a50", o_Result_Valid, o_Result);
        end
        exp_hits++;
        step();
        checks++;
        if (o_Result_Valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_pulse: valid=%b one cycle after result, want 0", o_Result_Valid);
        end
    endtask

    task automatic test_kill();
        drive_vec(set_seg(uniform(2'b01, 8'h2A), 4, 2'b00, 8'h2A), 1'b1);
        step();
        step();
        checks++;
        if (o_Result_Valid !== 1'b1 || o_Result !== 17'h00000) begin
            errors++;
            $display("FAIL t2_killed: valid=%b result=%h, want valid=1 result=00000", o_Result_Valid, o_Result);
        end
        drive_vec(set_seg(uniform(2'b01, 8'h2A), 7, 2'b10, 8'h2A), 1'b1);
        step();
        step();
        checks++;
        if (o_Result_Valid !== 1'b1 || o_Result !== 17'h00000) begin
            errors++;
            $display("FAIL t2_status10: valid=%b result=%h, want valid=1 result=00000", o_Result_Valid, o_Result);
        end
    endtask

    task automatic test_masked();
        write_prio(8'h07, 8'h33);
        drive_vec(set_seg(uniform(2'b11, 8'hFF), 12, 2'b01, 8'h07), 1'b1);
        step();
        step();
        checks++;
        if (o_Result_Valid !== 1'b1 || o_Result !== 17'h10733) begin
            errors++;
            $display("FAIL t3_seg12: valid=%b result=%h, want valid=1 result=10733", o_Result_Valid, o_Result);
        end
        exp_hits++;
        drive_vec(uniform(2'b11, 8'h07), 1'b1);
        step();
        step();
        checks++;
        if (o_Result_Valid !== 1'b1 || o_Result !== 17'h00000) begin
            errors++;
            $display("FAIL t3_all_masked: valid=%b result=%h, want valid=1 result=00000", o_Result_Valid, o_Result);
        end
    endtask

    task automatic test_back_to_back();
        write_prio(8'h10, 8'h20);
        write_prio(8'h11, 8'h90);
        write_prio(8'h12, 8'h90);
        drive_vec(uniform(2'b01, 8'h10), 1'b0);
        drive_vec(uniform(2'b01, 8'h11), 1'b0);
        drive_vec(uniform(2'b01, 8'h12), 1'b1);
        drive_vec(uniform(2'b01, 8'h10), 1'b1);
        step();
        checks++;
        if (o_Result_Valid !== 1'b1 || o_Result !== 17'h11190) begin
            errors++;
            $display("FAIL t4_tie: valid=%b result=%h, want valid=1 result=11190", o_Result_Valid, o_Result);
        end
        exp_hits++;
        step();
        checks++;
        if (o_Result_Valid !== 1'b1 || o_Result !== 17'h11020) begin
            errors++;
            $display("FAIL t4_b2b: valid=%b result=%h, want valid=1 result=11020", o_Result_Valid, o_Result);
        end
        exp_hits++;
        step();
        checks++;
        if (o_Result_Valid !== 1'b0) begin
            errors++;
            $display("FAIL t4_idle: valid=%b after frames, want 0", o_Result_Valid);
        end
    endtask

    task automatic test_gaps();
        drive_vec(set_seg(uniform(2'b01, 8'h10), 3, 2'b00, 8'h10), 1'b0);
        step();
        step();
        drive_vec(uniform(2'b01, 8'h12), 1'b0);
        step();
        drive_vec(uniform(2'b01, 8'h10), 1'b1);
        step();
        step();
        checks++;
        if (o_Result_Valid !== 1'b1 || o_Result !== 17'h11290) begin
            errors++;
            $display("FAIL gaps_result: valid=%b result=%h, want valid=1 result=11290", o_Result_Valid, o_Result);
        end
        exp_hits++;
    endtask

    task automatic test_conflict_and_read_first();
        drive_vec(set_seg(set_seg(uniform(2'b11, 8'h00), 0, 2'b01, 8'h01), 1, 2'b01, 8'h02), 1'b1);
        step();
        step();
        checks++;
        if (o_Result_Valid !== 1'b1 || o_Result !== 17'h00000) begin
            errors++;
            $display("FAIL t5_conflict: valid=%b result=%h, want valid=1 result=00000", o_Result_Valid, o_Result);
        end
        write_prio(8'h05, 8'h44);
        drive_vec(uniform(2'b01, 8'h05), 1'b1);
        write_prio(8'h05, 8'h0A);
        step();
        checks++;
        if (o_Result_Valid !== 1'b1 || o_Result !== 17'h10544) begin
            errors++;
            $display("FAIL t5_read_first: valid=%b result=%h, want valid=1 result=10544", o_Result_Valid, o_Result);
        end
        exp_hits++;
        drive_vec(uniform(2'b01, 8'h05), 1'b1);
        step();
        step();
        checks++;
        if (o_Result_Valid !== 1'b1 || o_Result !== 17'h1050A) begin
            errors++;
            $display("FAIL t5_new_value: valid=%b result=%h, want valid=1 result=1050a", o_Result_Valid, o_Result);
        end
        exp_hits++;
`ifdef SEGVECT_HITCNT_EN
        step();
        checks++;
        if (o_Hit_Cnt !== exp_hits[15:0]) begin
            errors++;
            $display("FAIL hitcnt_count: got %0d want %0d", o_Hit_Cnt, exp_hits);
        end
`endif
    endtask

    task automatic test_mid_frame_reset();
        int seen;
        drive_vec(uniform(2'b01, 8'h10), 1'b0);
        drive_vec(uniform(2'b01, 8'h11), 1'b0);
        rst = 1'b0;
        #2;
        checks++;
        if (o_Result_Valid !== 1'b0 || o_Result !== 17'h00000) begin
            errors++;
            $display("FAIL t6_in_reset: valid=%b result=%h, want valid=0 result=00000", o_Result_Valid, o_Result);
        end
        exp_hits = 0;
        #2;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (o_Result_Valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL t6_no_result: got %0d result pulses after reset, want 0", seen);
        end
        drive_vec(uniform(2'b01, 8'h11), 1'b1);
        step();
        step();
        checks++;
        if (o_Result_Valid !== 1'b1 || o_Result !== 17'h11190) begin
            errors++;
            $display("FAIL t6_after_reset: valid=%b result=%h, want valid=1 result=11190", o_Result_Valid, o_Result);
        end
        exp_hits++;
`ifdef SEGVECT_HITCNT_EN
        drive_vec(uniform(2'b11, 8'h00), 1'b1);
        step();
        step();
        step();
        checks++;
        if (o_Hit_Cnt !== exp_hits[15:0]) begin
            errors++;
            $display("FAIL hitcnt_after_reset: got %0d want %0d", o_Hit_Cnt, exp_hits);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_rule();
        test_kill();
        test_masked();
        test_back_to_back();
        test_gaps();
        test_conflict_and_read_first();
        test_mid_frame_reset();
        $display("matched frames since last reset: %0d", exp_hits);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
